// File: rtl/fpu_issue_wb.sv
// Operand-fetch / writeback stage around the combinational FPU: holds the FP
// register file, the fcc condition flag and the sticky exception flags.
module fpu_issue_wb #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter bit CC_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_fs,
  input  logic [ADDR_W-1:0] in_ft,
  input  logic [ADDR_W-1:0] in_fd,
  output logic [31:0]       fpu_a,
  output logic [31:0]       fpu_b,
  output logic [3:0]        fpu_op,
  input  logic [31:0]       fpu_result,
  input  logic              fpu_cc,
  input  logic              fpu_invalid,
  input  logic              fpu_overflow,
  input  logic              fpu_underflow,
  output logic              done_valid,
  output logic [ADDR_W-1:0] done_fd,
  output logic              fcc,
  output logic [2:0]        flags_sticky,
  input  logic              flags_clear,
  input  logic              ext_wr_en,
  input  logic [ADDR_W-1:0] ext_wr_addr,
  input  logic [31:0]       ext_wr_data,
  input  logic [ADDR_W-1:0] ext_rd_addr,
  output logic [31:0]       ext_rd_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t              state;
  logic [31:0]         regs [NUM_REGS];
  logic [ADDR_W-1:0]   fd_q;
  logic [31:0]         res_q;
  logic                cc_q;
  logic                inv_q;
  logic                ovf_q;
  logic                unf_q;

  logic                is_write;
  logic                is_cmp;
  logic                is_bad;
  logic                commit_wr;
  logic                ext_wr_ok;
  logic [2:0]          sticky_set;

  // fpu_op stays registered through WB, so it also decodes the commit action.
  always_comb begin
    is_write   = (fpu_op == 4'b0000) || (fpu_op == 4'b0001) ||
                 (fpu_op == 4'b0010) || (fpu_op == 4'b1000);
    is_cmp     = (fpu_op >= 4'b0011) && (fpu_op <= 4'b0111);
    is_bad     = !(is_write || is_cmp);
    commit_wr  = (state == WB) && is_write;
    ext_wr_ok  = ext_wr_en && !(commit_wr && (ext_wr_addr == fd_q));
    sticky_set = (state == WB) ? {inv_q | is_bad, ovf_q, unf_q} : 3'b000;
  end

  assign in_ready    = (state == IDLE);
  assign ext_rd_data = regs[ext_rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fpu_a        <= '0;
      fpu_b        <= '0;
      fpu_op       <= '0;
      fd_q         <= '0;
      res_q        <= '0;
      cc_q         <= 1'b0;
      inv_q        <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      done_valid   <= 1'b0;
      done_fd      <= '0;
      fcc          <= CC_RESET;
      flags_sticky <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      done_valid   <= 1'b0;
      flags_sticky <= (flags_clear ? 3'b000 : flags_sticky) | sticky_set;

      // Commit has priority over an ext write to the same register.
      if (ext_wr_ok) regs[ext_wr_addr] <= ext_wr_data;
      if (commit_wr) regs[fd_q] <= res_q;

      case (state)
        IDLE: begin
          if (in_valid) begin
            fpu_a  <= regs[in_fs];
            fpu_b  <= regs[in_ft];
            fpu_op <= in_op;
            fd_q   <= in_fd;
            state  <= EXEC;
          end
        end
        EXEC: begin
          res_q      <= fpu_result;
          cc_q       <= fpu_cc;
          inv_q      <= fpu_invalid;
          ovf_q      <= fpu_overflow;
          unf_q      <= fpu_underflow;
          done_valid <= 1'b1;
          done_fd    <= fd_q;
          state      <= WB;
        end
        WB: begin
          if (is_cmp) fcc <= cc_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
